// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Line geometry and responder FSM encoding shared with the dcache.
// Revision : 1.0
// ============================================================================
package dmem_pkg;

    localparam int LINE_W          = 256;
    localparam int OFFSET_W        = 5;
    localparam int DEFAULT_LATENCY = 10;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/dmem_line_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_line_array
// Purpose  : Single-port DEPTH x LINE_W line store; read data is registered and
//            only updated on a read strobe.
// Revision : 1.0
// ============================================================================
module dmem_line_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int IDX_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] r_mem [DEPTH];

    // Storage itself is never cleared by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= r_mem[idx];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_line_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_line_responder
// Purpose  : Fixed-latency line read/write responder for the dcache refill
//            port. Optional DMEM_ALIGN_CHECK_EN adds err_o for offset != 0.
// Revision : 1.0
// ============================================================================
module dmem_line_responder
    import dmem_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY,
    parameter int DEPTH   = 512,
    parameter int IDX_W   = 9
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic              ack_o,
`ifdef DMEM_ALIGN_CHECK_EN
    output logic              err_o,
`endif
    output logic [LINE_W-1:0] data_o
);

    localparam logic [7:0] c_LOAD   = 8'(LATENCY - 1);
    localparam bit         c_DIRECT = (LATENCY == 1);

    logic [1:0]        r_state;
    logic [7:0]        r_count;
    logic              r_write;
    logic [IDX_W-1:0]  r_idx;
    logic [LINE_W-1:0] r_data;
    logic              r_misalign;

    logic              w_accept;
    logic              w_commit;
    logic              w_wr;
    logic              w_bad;
    logic              w_live_bad;
    logic [IDX_W-1:0]  w_idx_in;
    logic [IDX_W-1:0]  w_idx;
    logic [LINE_W-1:0] w_wdata;
    logic              w_we;
    logic              w_re;

    assign w_idx_in = addr_i[OFFSET_W +: IDX_W];
    assign w_accept = (r_state == IDLE) && enable_i;

`ifdef DMEM_ALIGN_CHECK_EN
    logic w_unused_hi;
    assign w_unused_hi = ^addr_i[31:OFFSET_W+IDX_W];
    assign w_live_bad  = (addr_i[OFFSET_W-1:0] != '0);
    assign err_o       = (r_state == ACK) && r_misalign;
`else
    logic w_unused_bits;
    assign w_unused_bits = ^{addr_i[31:OFFSET_W+IDX_W], addr_i[OFFSET_W-1:0]};
    assign w_live_bad    = 1'b0;
`endif

    // With LATENCY=1 the commit happens on the acceptance edge, so it must
    // use the live request rather than the latched copy.
    assign w_wr    = c_DIRECT ? write_i    : r_write;
    assign w_idx   = c_DIRECT ? w_idx_in   : r_idx;
    assign w_wdata = c_DIRECT ? data_i     : r_data;
    assign w_bad   = c_DIRECT ? w_live_bad : r_misalign;

    assign w_commit = !rst_i && ((c_DIRECT && w_accept) ||
                                 (!c_DIRECT && (r_state == BUSY) && (r_count <= 8'd1)));
    assign w_we     = w_commit && w_wr && !w_bad;
    assign w_re     = w_commit && !w_wr;
    assign ack_o    = (r_state == ACK);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_count    <= 8'd0;
            r_write    <= 1'b0;
            r_idx      <= '0;
            r_data     <= '0;
            r_misalign <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable_i) begin
                        r_write    <= write_i;
                        r_idx      <= w_idx_in;
                        r_data     <= data_i;
                        r_misalign <= w_live_bad;
                        if (c_DIRECT) begin
                            r_state <= ACK;
                        end else begin
                            r_state <= BUSY;
                            r_count <= c_LOAD;
                        end
                    end
                end
                BUSY: begin
                    r_count <= r_count - 8'd1;
                    if (r_count <= 8'd1) begin
                        r_state <= ACK;
                    end
                end
                ACK:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    dmem_line_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk_i),
        .rst   (rst_i),
        .we    (w_we),
        .re    (w_re),
        .idx   (w_idx),
        .wdata (w_wdata),
        .rdata (data_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_dmem_line_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_line_responder
// Purpose  : Directed self-checking bench for dmem_line_responder (LATENCY=10).
// Revision : 1.0
// ============================================================================
module tb_dmem_line_responder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic         write = 1'b0;
    logic [31:0]  addr = '0;
    logic [255:0] data_in = '0;
    logic         ack;
    logic [255:0] data_out;
`ifdef DMEM_ALIGN_CHECK_EN
    logic         err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [255:0] c_A5 = {32{8'hA5}};
    localparam logic [255:0] c_11 = {32{8'h11}};
    localparam logic [255:0] c_22 = {32{8'h22}};
    localparam logic [255:0] c_33 = {32{8'h33}};
    localparam logic [255:0] c_44 = {32{8'h44}};
    localparam logic [255:0] c_55 = {32{8'h55}};

    dmem_line_responder u_dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .enable_i (enable),
        .write_i  (write),
        .addr_i   (addr),
        .data_i   (data_in),
        .ack_o    (ack),
`ifdef DMEM_ALIGN_CHECK_EN
        .err_o    (err),
`endif
        .data_o   (data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns the number of negedges after the current point until ack is seen.
    task automatic wait_ack(output int n);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ack) begin
                n = k;
                break;
            end
        end
    endtask

    // Full request; request inputs are scrambled once BUSY, and enable drops
    // in the ack cycle. Returns at the negedge of the ack cycle.
    task automatic req(input logic wr, input logic [31:0] a, input logic [255:0] d,
                       output int lat);
        @(negedge clk);
        enable = 1'b1; write = wr; addr = a; data_in = d;
        @(posedge clk);
        @(negedge clk);
        lat = -1;
        if (ack) begin
            lat = 1;
        end else begin
            write = ~wr; addr = ~a; data_in = ~d;
            wait_ack(lat);
            if (lat > 0) lat = lat + 1;
        end
        enable = 1'b0;
    endtask

    initial begin
        int lat;
        int acks;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_ack", 256'(ack), 256'(1'b0));
        chk("reset_data", data_out, '0);

        req(1'b1, 32'h0000_0400, c_A5, lat);
        chk("wr400_latency", 256'(lat), 256'(10));

        req(1'b0, 32'h0000_0400, '0, lat);
        chk("rd400_latency", 256'(lat), 256'(10));
        chk("rd400_data_at_ack", data_out, c_A5);
        @(negedge clk);
        chk("rd400_data_hold", data_out, c_A5);
        chk("rd400_ack_single", 256'(ack), 256'(1'b0));

        // enable held through ack and dropped in the following IDLE cycle
        @(negedge clk);
        enable = 1'b1; write = 1'b0; addr = 32'h0000_0400;
        @(posedge clk);
        wait_ack(lat);
        chk("held_latency", 256'(lat), 256'(10));
        @(negedge clk);
        enable = 1'b0;
        acks = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (ack) acks++;
        end
        chk("held_no_reaccept", 256'(acks), 256'(0));

        req(1'b1, 32'h0000_0C00, c_44, lat);
        chk("wrC00_latency", 256'(lat), 256'(10));
        chk("write_keeps_data_o", data_out, c_A5);

        // writeback then refill with enable held across the ack
        @(negedge clk);
        enable = 1'b1; write = 1'b1; addr = 32'h0000_0800; data_in = c_11;
        @(posedge clk);
        wait_ack(lat);
        chk("b2b_wr_latency", 256'(lat), 256'(10));
        write = 1'b0; addr = 32'h0000_0C00;
        wait_ack(lat);
        enable = 1'b0;
        chk("b2b_ack_gap", 256'(lat), 256'(11));
        chk("b2b_refill_data", data_out, c_44);

        req(1'b0, 32'h0000_0800, '0, lat);
        chk("rd800_data", data_out, c_11);

        req(1'b1, 32'h0000_4000, c_22, lat);
        req(1'b0, 32'h0000_0000, '0, lat);
        chk("alias_latency", 256'(lat), 256'(10));
        chk("alias_data", data_out, c_22);

        req(1'b1, 32'h0000_0100, c_55, lat);

        // reset in cycle 5 of an in-flight write
        @(negedge clk);
        enable = 1'b1; write = 1'b1; addr = 32'h0000_0100; data_in = c_33;
        @(posedge clk);
        acks = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (ack) acks++;
            if (k == 5) begin
                rst = 1'b1;
                enable = 1'b0;
            end
            if (k == 6) rst = 1'b0;
        end
        chk("rst_mid_no_ack", 256'(acks), 256'(0));
        chk("rst_mid_data_cleared", data_out, '0);
        req(1'b0, 32'h0000_0100, '0, lat);
        chk("rst_mid_old_contents", data_out, c_55);

`ifdef DMEM_ALIGN_CHECK_EN
        req(1'b1, 32'h0000_0104, c_33, lat);
        chk("misalign_wr_err", 256'(err), 256'(1'b1));
        req(1'b0, 32'h0000_0100, '0, lat);
        chk("aligned_rd_err", 256'(err), 256'(1'b0));
        chk("misalign_wr_no_write", data_out, c_55);
        req(1'b0, 32'h0000_0104, '0, lat);
        chk("misalign_rd_err", 256'(err), 256'(1'b1));
        chk("misalign_rd_data", data_out, c_55);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
